// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and frame constants.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud
  localparam int unsigned DATA_WIDTH_DEFAULT   = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins; reset value selectable per bit.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized rx line, one-cycle byte
// strobe on axiov/axiod, framing-error pulse, and break suppression.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT      = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned SAMPLE_DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(SAMPLE_DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(SAMPLE_DATA_WIDTH - 1);

  logic rx_s;

  rx_state_t                    state,     state_nxt;
  logic [BAUD_W-1:0]            baud_cnt,  baud_nxt;
  logic [BIT_W-1:0]             bit_cnt,   bit_nxt;
  logic [SAMPLE_DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [SAMPLE_DATA_WIDTH-1:0] axiod_nxt;
  logic                         axiov_nxt, frame_err_nxt, busy_nxt;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      axiov     <= 1'b0;
      axiod     <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      axiov     <= axiov_nxt;
      axiod     <= axiod_nxt;
      frame_err <= frame_err_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt     = state;
    baud_nxt      = baud_cnt;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift_reg;
    axiov_nxt     = 1'b0;
    axiod_nxt     = axiod;
    frame_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_nxt = START;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end

      // Re-check the start bit at its midpoint to reject short glitches
      START: begin
        if (baud_cnt == HALF_BIT) begin
          baud_nxt  = '0;
          state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_cnt == FULL_BIT) begin
          baud_nxt  = '0;
          shift_nxt = SAMPLE_DATA_WIDTH'({rx_s, shift_reg} >> 1);
          bit_nxt   = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      // Leave half a bit early so a back-to-back start edge is not missed
      STOP: begin
        if (baud_cnt == FULL_BIT) begin
          baud_nxt = '0;
          if (rx_s == STOP_BIT) begin
            axiov_nxt = 1'b1;
            axiod_nxt = shift_reg;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end

      BREAK: begin
        if (rx_s == STOP_BIT) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit: expected bytes are queued as frames
// are driven and compared when axiov fires; counters track pulses and busy time.
module tb_uart_rx;

  localparam int unsigned CPB    = 16;
  localparam int          BIT_NS = 160;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       axiov;
  logic [7:0] axiod;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         n_axiov = 0;
  int         n_ferr = 0;
  int         last_axiov_cyc = 0;
  int         busy_run = 0;
  int         busy_max = 0;

  int base_ax, base_fe, start_cyc;

  uart_rx #(
    .CLKS_PER_BIT      (CPB),
    .SAMPLE_DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .axiov     (axiov),
    .axiod     (axiod),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse/busy monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (axiov) begin
      n_axiov++;
      last_axiov_cyc = cyc;
      check("axiov_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("axiod_byte", 32'(axiod), 32'(exp_q.pop_front()));
    end
    if (frame_err) n_ferr++;
    if (busy) busy_run++;
    else busy_run = 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  task automatic align();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_val);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic snap();
    base_ax = n_axiov;
    base_fe = n_ferr;
  endtask

  initial begin
    logic [7:0] partial;

    // Reset values
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_cycles(3);
    check("reset_axiov", 32'(axiov), 32'd0);
    check("reset_axiod", 32'(axiod), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);

    // Single frame 0xA5 with latency window
    align();
    snap();
    start_cyc = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, BIT_NS, 1'b1);
    wait_cycles(20);
    check("a5_axiov_count", 32'(n_axiov - base_ax), 32'd1);
    check("a5_no_frame_err", 32'(n_ferr - base_fe), 32'd0);
    check("a5_latency_window", 32'((last_axiov_cyc - start_cyc) >= 150 &&
                                   (last_axiov_cyc - start_cyc) <= 158), 32'd1);
    check("a5_busy_idle", 32'(busy), 32'd0);

    // Back-to-back 0x00 then 0xFF, stop bit exactly one bit period
    align();
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, BIT_NS, 1'b1);
    send_byte(8'hFF, BIT_NS, 1'b1);
    wait_cycles(20);
    check("b2b_axiov_count", 32'(n_axiov - base_ax), 32'd2);
    check("b2b_no_frame_err", 32'(n_ferr - base_fe), 32'd0);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // 5-cycle glitch is rejected at the start-bit midpoint
    align();
    snap();
    busy_max = 0;
    rx = 1'b0;
    #50;
    rx = 1'b1;
    wait_cycles(40);
    check("glitch_no_axiov", 32'(n_axiov - base_ax), 32'd0);
    check("glitch_no_frame_err", 32'(n_ferr - base_fe), 32'd0);
    check("glitch_busy_short", 32'(busy_max > 0 && busy_max < 12), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);

    // Low stop bit followed by a held-low line: one error, axiod kept
    align();
    snap();
    send_byte(8'h3C, BIT_NS, 1'b0);
    #1000;
    rx = 1'b1;
    wait_cycles(30);
    check("break_frame_err_count", 32'(n_ferr - base_fe), 32'd1);
    check("break_no_axiov", 32'(n_axiov - base_ax), 32'd0);
    check("break_axiod_held", 32'(axiod), 32'hFF);
    check("break_busy_idle", 32'(busy), 32'd0);

    align();
    snap();
    exp_q.push_back(8'h42);
    send_byte(8'h42, BIT_NS, 1'b1);
    wait_cycles(20);
    check("after_break_axiov_count", 32'(n_axiov - base_ax), 32'd1);
    check("after_break_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of bit 4 of 0x81
    align();
    snap();
    partial = 8'h81;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      #(BIT_NS);
    end
    rx = partial[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("midreset_axiov", 32'(axiov), 32'd0);
    check("midreset_axiod", 32'(axiod), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    #21;
    rst_n = 1'b1;
    wait_cycles(20);
    check("postreset_no_axiov", 32'(n_axiov - base_ax), 32'd0);
    check("postreset_no_frame_err", 32'(n_ferr - base_fe), 32'd0);
    check("postreset_busy", 32'(busy), 32'd0);
    check("postreset_axiod", 32'(axiod), 32'd0);

    align();
    snap();
    exp_q.push_back(8'h81);
    send_byte(8'h81, BIT_NS, 1'b1);
    wait_cycles(20);
    check("after_reset_axiov_count", 32'(n_axiov - base_ax), 32'd1);
    check("after_reset_queue_drained", 32'(exp_q.size()), 32'd0);

    // About 3% baud skew each way: 15.5 and 16.5 clocks per bit
    align();
    snap();
    exp_q.push_back(8'h55);
    send_byte(8'h55, 155, 1'b1);
    wait_cycles(20);
    align();
    exp_q.push_back(8'h55);
    send_byte(8'h55, 165, 1'b1);
    wait_cycles(20);
    check("skew_axiov_count", 32'(n_axiov - base_ax), 32'd2);
    check("skew_no_frame_err", 32'(n_ferr - base_fe), 32'd0);
    check("skew_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
